// File: rtl/ddr_iod_dly_ctrl.sv
// ddr_iod_dly_ctrl: converts absolute per-lane tap targets into paced IOD move/load pulses
//   FAB_CLK, SYNC_RST         : clock, synchronous active-high reset
//   CMD_VALID/READY/LOAD/LANE/TAP : command handshake and payload (LOAD=1 reloads INIT_TAP)
//   DONE, ERR, ERR_LANE, BUSY : completion pulse, sticky out-of-range flag and lane, activity
//   TAP_CUR                   : tracked tap of every lane, lane i at [i*TAP_WIDTH +: TAP_WIDTH]
//   DELAY_LINE_*              : per-lane IOD move/direction/load outputs and out-of-range input
module ddr_iod_dly_ctrl #(
    parameter int NUM_LANES     = 16,
    parameter int TAP_WIDTH     = 8,
    parameter int INIT_TAP      = 1,
    parameter int MAX_TAP       = 255,
    parameter int SETTLE_CYCLES = 2,
    parameter int LANE_W        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                           FAB_CLK,
    input  logic                           SYNC_RST,
    input  logic                           CMD_VALID,
    output logic                           CMD_READY,
    input  logic                           CMD_LOAD,
    input  logic [LANE_W-1:0]              CMD_LANE,
    input  logic [TAP_WIDTH-1:0]           CMD_TAP,
    output logic                           DONE,
    output logic                           ERR,
    output logic [LANE_W-1:0]              ERR_LANE,
    output logic                           BUSY,
    output logic [NUM_LANES*TAP_WIDTH-1:0] TAP_CUR,
    output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_SETTLE, S_LDP, S_LDSETTLE, S_FIN} state_t;

    state_t                 r_state, w_next;
    logic [TAP_WIDTH-1:0]   r_tap [NUM_LANES];
    logic [LANE_W-1:0]      r_lane, r_err_lane;
    logic [TAP_WIDTH-1:0]   r_tgt;
    logic                   r_dir, r_err;
    logic [CW-1:0]          r_cnt;
    logic                   w_acc, w_lane_ok, w_settle_end, w_oor, w_oor_hit;
    logic [TAP_WIDTH-1:0]   w_tgt, w_cmd_cur, w_cur;

    assign w_acc        = CMD_VALID && (r_state == S_IDLE);
    assign w_lane_ok    = {1'b0, CMD_LANE} < (LANE_W + 1)'(NUM_LANES);
    assign w_tgt        = (CMD_TAP > TAP_WIDTH'(MAX_TAP)) ? TAP_WIDTH'(MAX_TAP) : CMD_TAP;
    assign w_settle_end = r_cnt == CW'(SETTLE_CYCLES - 1);
    assign w_oor_hit    = (r_state == S_SETTLE) && w_settle_end && w_oor;

    // Lane muxes written as loops so a non-power-of-two lane count never indexes past the array
    always_comb begin
        w_cmd_cur = '0;
        w_cur     = '0;
        w_oor     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (CMD_LANE == LANE_W'(i)) w_cmd_cur = r_tap[i];
            if (r_lane == LANE_W'(i)) begin
                w_cur = r_tap[i];
                w_oor = DELAY_LINE_OUT_OF_RANGE[i];
            end
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_acc) w_next = !w_lane_ok ? S_FIN : CMD_LOAD ? S_LDP :
                                            (w_tgt == w_cmd_cur) ? S_FIN : S_SETUP;
            S_SETUP:    w_next = S_STEP;
            S_STEP:     w_next = S_SETTLE;
            S_SETTLE:   if (w_settle_end) w_next = (w_oor || w_cur == r_tgt) ? S_FIN : S_STEP;
            S_LDP:      w_next = S_LDSETTLE;
            S_LDSETTLE: if (w_settle_end) w_next = S_FIN;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= TAP_WIDTH'(INIT_TAP);
            r_lane     <= '0;
            r_tgt      <= '0;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_lane <= '0;
        end else begin
            r_cnt <= (r_state == S_STEP || r_state == S_LDP) ? '0 : r_cnt + 1'b1;
            if (w_acc) begin
                r_lane <= CMD_LANE;
                r_tgt  <= w_tgt;
                r_dir  <= w_tgt > w_cmd_cur;
                r_err  <= !w_lane_ok;
                if (!w_lane_ok) r_err_lane <= CMD_LANE;
            end
            if (w_oor_hit) begin
                r_err      <= 1'b1;
                r_err_lane <= r_lane;
            end
            // The IOD refused the last step, so the count change made in STEP is reverted
            for (int i = 0; i < NUM_LANES; i++) begin
                if (r_lane == LANE_W'(i)) begin
                    if (r_state == S_STEP)      r_tap[i] <= r_dir ? r_tap[i] + 1'b1 : r_tap[i] - 1'b1;
                    else if (w_oor_hit)         r_tap[i] <= r_dir ? r_tap[i] - 1'b1 : r_tap[i] + 1'b1;
                    else if (r_state == S_LDP)  r_tap[i] <= TAP_WIDTH'(INIT_TAP);
                end
            end
        end
    end

    always_comb begin
        DELAY_LINE_MOVE      = '0;
        DELAY_LINE_LOAD      = '0;
        DELAY_LINE_DIRECTION = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            DELAY_LINE_MOVE[i]      = (r_lane == LANE_W'(i)) && (r_state == S_STEP);
            DELAY_LINE_LOAD[i]      = (r_lane == LANE_W'(i)) && (r_state == S_LDP);
            DELAY_LINE_DIRECTION[i] = (r_lane == LANE_W'(i)) && r_dir &&
                                      (r_state == S_SETUP || r_state == S_STEP || r_state == S_SETTLE);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_tap
            assign TAP_CUR[g*TAP_WIDTH +: TAP_WIDTH] = r_tap[g];
        end
    endgenerate

    assign CMD_READY = r_state == S_IDLE;
    assign BUSY      = r_state != S_IDLE;
    assign DONE      = r_state == S_FIN;
    assign ERR       = r_err;
    assign ERR_LANE  = r_err_lane;
endmodule

// File: tb/tb_ddr_iod_dly_ctrl.sv
// tb_ddr_iod_dly_ctrl: directed and randomized checks of the IOD delay controller against a tap model
module tb_ddr_iod_dly_ctrl;
    localparam int NL = 12, TW = 9, IT = 1, MT = 255, SC = 2, LW = 4;

    logic              clk = 1'b0, rst;
    logic              valid, ready, load, done, err, busy;
    logic [LW-1:0]     lane, err_lane;
    logic [TW-1:0]     tap;
    logic [NL*TW-1:0]  tap_cur;
    logic [NL-1:0]     mv, dir, ld, oor;

    always #5 clk = ~clk;

    ddr_iod_dly_ctrl #(.NUM_LANES(NL), .TAP_WIDTH(TW), .INIT_TAP(IT), .MAX_TAP(MT),
                       .SETTLE_CYCLES(SC)) dut (
        .FAB_CLK(clk), .SYNC_RST(rst), .CMD_VALID(valid), .CMD_READY(ready),
        .CMD_LOAD(load), .CMD_LANE(lane), .CMD_TAP(tap), .DONE(done), .ERR(err),
        .ERR_LANE(err_lane), .BUSY(busy), .TAP_CUR(tap_cur), .DELAY_LINE_MOVE(mv),
        .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(ld), .DELAY_LINE_OUT_OF_RANGE(oor));

    int compared = 0, mismatched = 0;
    int model_tap [NL];
    int model_err, model_err_lane;
    int o_done, o_moves, o_loads, o_first, o_last, o_load_cyc, o_stray, o_dir1, o_dir_chg;
    int o_dir_done, o_busy1, o_ready1, o_ready_after, o_done_after, o_err, o_err_lane;
    int e_done, e_moves, e_loads, e_dir;

    // Expected outcome of one command derived from the tap arithmetic, updating the model lanes
    task automatic predict(input bit l_load, input int l_lane, input int l_tap, input int oor_after);
        int cur, tgt, steps;
        e_moves = 0; e_loads = 0; e_dir = 0;
        if (l_lane >= NL) begin
            model_err = 1; model_err_lane = l_lane; e_done = 1;
            return;
        end
        model_err = 0;
        if (l_load) begin
            model_tap[l_lane] = IT; e_loads = 1; e_done = 2 + SC;
            return;
        end
        cur = model_tap[l_lane];
        tgt = (l_tap > MT) ? MT : l_tap;
        if (tgt == cur) begin
            e_done = 1;
            return;
        end
        e_dir = (tgt > cur) ? 1 : 0;
        steps = e_dir ? tgt - cur : cur - tgt;
        if (oor_after > 0 && oor_after <= steps) begin
            steps = oor_after;
            model_err = 1; model_err_lane = l_lane;
            model_tap[l_lane] = e_dir ? cur + steps - 1 : cur - steps + 1;
        end else model_tap[l_lane] = tgt;
        e_moves = steps;
        e_done = 2 + steps * (1 + SC);
    endtask

    // Drives one command and records what the DUT did, cycle 0 being the accept edge
    task automatic issue(input bit l_load, input int l_lane, input int l_tap, input int oor_after);
        @(negedge clk);
        valid = 1'b1; load = l_load; lane = LW'(l_lane); tap = TW'(l_tap);
        @(posedge clk);
        #1 valid = 1'b0;
        o_done = -1; o_moves = 0; o_loads = 0; o_first = -1; o_last = -1; o_load_cyc = -1;
        o_stray = 0; o_dir1 = 0; o_dir_chg = 0; o_dir_done = 0; o_busy1 = 0; o_ready1 = 1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                o_busy1 = busy; o_ready1 = ready;
                o_dir1 = (l_lane < NL) ? int'(dir[l_lane]) : 0;
            end
            for (int i = 0; i < NL; i++)
                if (i != l_lane && (mv[i] || ld[i] || dir[i])) o_stray++;
            if (l_lane < NL) begin
                if (mv[l_lane]) begin
                    o_moves++;
                    if (o_first < 0) o_first = c;
                    o_last = c;
                    if (o_moves == oor_after) oor[l_lane] = 1'b1;
                end
                if (ld[l_lane]) begin o_loads++; o_load_cyc = c; end
                if (done) o_dir_done = dir[l_lane];
                else if (int'(dir[l_lane]) != o_dir1) o_dir_chg++;
            end
            if (done) begin o_done = c; break; end
        end
        oor = '0;
        @(negedge clk);
        o_ready_after = ready; o_done_after = done; o_err = err; o_err_lane = err_lane;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; load = 1'b0; lane = '0; tap = '0; oor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", ready); end
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        compared++; if (err !== 1'b0 || err_lane !== '0) begin mismatched++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_lane); end
        compared++; if ((mv | dir | ld) !== '0) begin mismatched++; $display("FAIL reset_lines: got %h/%h/%h want 0", mv, dir, ld); end
        for (int i = 0; i < NL; i++) begin
            model_tap[i] = IT;
            compared++;
            if (int'(tap_cur[i*TW +: TW]) !== IT) begin
                mismatched++; $display("FAIL reset_tap lane %0d: got %0d want %0d", i, tap_cur[i*TW +: TW], IT);
            end
        end
        model_err = 0; model_err_lane = 0;
        rst = 1'b0;
    endtask

    task automatic test_move_up_down();
        predict(0, 3, 4, 0); issue(0, 3, 4, 0);
        compared++; if (o_dir1 !== 1) begin mismatched++; $display("FAIL up_dir: got %0d want 1", o_dir1); end
        compared++; if (o_moves !== 3 || o_first !== 2 || o_last !== 8) begin mismatched++; $display("FAIL up_pulses: got n=%0d first=%0d last=%0d want 3/2/8", o_moves, o_first, o_last); end
        compared++; if (o_done !== 11) begin mismatched++; $display("FAIL up_done: got %0d want 11", o_done); end
        compared++; if (int'(tap_cur[3*TW +: TW]) !== 4) begin mismatched++; $display("FAIL up_tap: got %0d want 4", tap_cur[3*TW +: TW]); end
        compared++; if (o_busy1 !== 1 || o_ready1 !== 0 || o_ready_after !== 1 || o_done_after !== 0) begin mismatched++; $display("FAIL up_handshake: got busy=%0d rdy=%0d rdy_after=%0d done_after=%0d want 1/0/1/0", o_busy1, o_ready1, o_ready_after, o_done_after); end
        predict(0, 3, 2, 0); issue(0, 3, 2, 0);
        compared++; if (o_dir1 !== 0 || o_moves !== 2 || o_done !== 8) begin mismatched++; $display("FAIL down: got dir=%0d n=%0d done=%0d want 0/2/8", o_dir1, o_moves, o_done); end
        compared++; if (int'(tap_cur[3*TW +: TW]) !== 2 || int'(tap_cur[0 +: TW]) !== 1) begin mismatched++; $display("FAIL down_tap: got l3=%0d l0=%0d want 2/1", tap_cur[3*TW +: TW], tap_cur[0 +: TW]); end
        compared++; if (o_stray !== 0) begin mismatched++; $display("FAIL down_stray: got %0d want 0", o_stray); end
    endtask

    task automatic test_equal_target();
        predict(0, 0, 1, 0); issue(0, 0, 1, 0);
        compared++; if (o_done !== 1 || o_moves !== 0 || o_err !== 0) begin mismatched++; $display("FAIL equal: got done=%0d n=%0d err=%0d want 1/0/0", o_done, o_moves, o_err); end
    endtask

    task automatic test_out_of_range();
        predict(0, 5, 10, 3); issue(0, 5, 10, 3);
        compared++; if (o_err !== 1 || o_err_lane !== 5) begin mismatched++; $display("FAIL oor_err: got %0d/%0d want 1/5", o_err, o_err_lane); end
        compared++; if (int'(tap_cur[5*TW +: TW]) !== 3) begin mismatched++; $display("FAIL oor_tap: got %0d want 3", tap_cur[5*TW +: TW]); end
        compared++; if (o_done !== 11 || o_moves !== 3) begin mismatched++; $display("FAIL oor_done: got done=%0d n=%0d want 11/3", o_done, o_moves); end
        predict(0, 5, 4, 0); issue(0, 5, 4, 0);
        compared++; if (o_err !== 0) begin mismatched++; $display("FAIL oor_clear: got %0d want 0", o_err); end
    endtask

    task automatic test_saturate_load();
        predict(0, 7, 300, 0); issue(0, 7, 300, 0);
        compared++; if (int'(tap_cur[7*TW +: TW]) !== 255 || o_moves !== 254 || o_done !== 764) begin mismatched++; $display("FAIL sat: got tap=%0d n=%0d done=%0d want 255/254/764", tap_cur[7*TW +: TW], o_moves, o_done); end
        predict(1, 7, 0, 0); issue(1, 7, 0, 0);
        compared++; if (o_loads !== 1 || o_load_cyc !== 1 || o_done !== 4 || o_moves !== 0) begin mismatched++; $display("FAIL load: got n=%0d at=%0d done=%0d mv=%0d want 1/1/4/0", o_loads, o_load_cyc, o_done, o_moves); end
        compared++; if (int'(tap_cur[7*TW +: TW]) !== 1 || o_dir1 !== 0) begin mismatched++; $display("FAIL load_tap: got %0d dir=%0d want 1/0", tap_cur[7*TW +: TW], o_dir1); end
    endtask

    task automatic test_bad_lane();
        predict(0, 13, 9, 0); issue(0, 13, 9, 0);
        compared++; if (o_err !== 1 || o_err_lane !== 13 || o_done !== 1 || o_stray !== 0) begin mismatched++; $display("FAIL bad_lane: got err=%0d lane=%0d done=%0d stray=%0d want 1/13/1/0", o_err, o_err_lane, o_done, o_stray); end
    endtask

    task automatic test_random();
        int r_lane, r_tap, r_oor, tap_bad;
        bit r_load;
        for (int n = 0; n < 40; n++) begin
            r_lane = ($urandom_range(0, 9) == 0) ? $urandom_range(NL, 15) : $urandom_range(0, NL - 1);
            r_load = ($urandom_range(0, 4) == 0);
            r_tap  = $urandom_range(0, 24);
            r_oor  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            predict(r_load, r_lane, r_tap, r_oor); issue(r_load, r_lane, r_tap, r_oor);
            compared++; if (o_done !== e_done) begin mismatched++; $display("FAIL rnd_done #%0d: got %0d want %0d", n, o_done, e_done); end
            compared++; if (o_moves !== e_moves || o_loads !== e_loads) begin mismatched++; $display("FAIL rnd_pulses #%0d: got mv=%0d ld=%0d want %0d/%0d", n, o_moves, o_loads, e_moves, e_loads); end
            if (e_moves > 0) begin
                compared++; if (o_first !== 2 || o_last !== 2 + (e_moves - 1) * (1 + SC)) begin mismatched++; $display("FAIL rnd_pace #%0d: got %0d..%0d want 2..%0d", n, o_first, o_last, 2 + (e_moves - 1) * (1 + SC)); end
            end
            compared++; if (o_dir1 !== e_dir || o_dir_chg !== 0 || o_dir_done !== 0) begin mismatched++; $display("FAIL rnd_dir #%0d: got %0d chg=%0d fin=%0d want %0d/0/0", n, o_dir1, o_dir_chg, o_dir_done, e_dir); end
            compared++; if (o_stray !== 0 || o_ready_after !== 1 || o_done_after !== 0) begin mismatched++; $display("FAIL rnd_misc #%0d: got stray=%0d rdy=%0d done=%0d want 0/1/0", n, o_stray, o_ready_after, o_done_after); end
            compared++; if (o_err !== model_err || (model_err == 1 && o_err_lane !== model_err_lane)) begin mismatched++; $display("FAIL rnd_err #%0d: got %0d/%0d want %0d/%0d", n, o_err, o_err_lane, model_err, model_err_lane); end
            tap_bad = 0;
            for (int i = 0; i < NL; i++) if (int'(tap_cur[i*TW +: TW]) != model_tap[i]) tap_bad++;
            compared++; if (tap_bad !== 0) begin mismatched++; $display("FAIL rnd_taps #%0d: got %0d lanes differing want 0", n, tap_bad); end
        end
    endtask

    task automatic test_reset_mid();
        int seen, after;
        @(negedge clk);
        valid = 1'b1; load = 1'b0; lane = 4'd2; tap = 9'd40;
        @(posedge clk);
        #1 valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (mv[2]) seen = 1;
        end
        compared++; if (seen !== 1) begin mismatched++; $display("FAIL mid_pulse: got %0d want 1", seen); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NL; i++) model_tap[i] = IT;
        compared++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL mid_state: got rdy=%b busy=%b done=%b err=%b want 1000", ready, busy, done, err); end
        compared++; if ((mv | dir | ld) !== '0 || int'(tap_cur[2*TW +: TW]) !== IT) begin mismatched++; $display("FAIL mid_lines: got %h/%h/%h tap=%0d want 0 tap=%0d", mv, dir, ld, tap_cur[2*TW +: TW], IT); end
        rst = 1'b0;
        after = 0;
        repeat (15) begin
            @(negedge clk);
            if (mv !== '0) after++;
        end
        compared++; if (after !== 0) begin mismatched++; $display("FAIL mid_after: got %0d pulses want 0", after); end
    endtask

    initial begin
        test_reset();
        test_move_up_down();
        test_equal_target();
        test_out_of_range();
        test_saturate_load();
        test_bad_lane();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ddr_iod_dly_ctrl.md
Name: ddr_iod_dly_ctrl

Overview:
Parametrised controller for the dynamic delay lines of the DDR PHY IOD lanes, covering both address/command and data lanes. It accepts absolute tap-target commands per lane and converts each one into a paced sequence of DELAY_LINE_MOVE pulses, with DELAY_LINE_DIRECTION set up before the first pulse. It also issues DELAY_LINE_LOAD, tracks the current tap count of every lane, and detects out-of-range from the IOD. It sits between PHY training logic and an array of NUM_LANES IOD instances, replacing hand-driven move/direction/load wiring.

Parameters:
NUM_LANES, 16, number of IOD lanes controlled (1..64)
TAP_WIDTH, 8, tap counter width; matches the IOD delay value width
INIT_TAP, 1, tap value a lane holds after reset or LOAD (the IOD static delay value)
MAX_TAP, 255, highest legal tap; targets above it are saturated
SETTLE_CYCLES, 2, idle FAB_CLK cycles after each move/load pulse (>=1)
LANE_W, $clog2(NUM_LANES) (min 1), lane index width

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
SYNC_RST  in  1  synchronous active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  controller can accept a command
CMD_LOAD  in  1  1 = load lane to INIT_TAP; 0 = move to CMD_TAP
CMD_LANE  in  LANE_W  target lane
CMD_TAP  in  TAP_WIDTH  absolute target tap
DONE  out  1  one-cycle pulse at command completion
ERR  out  1  sticky out-of-range flag; cleared by reset or by the next accepted command
ERR_LANE  out  LANE_W  lane that raised ERR
BUSY  out  1  command in progress
TAP_CUR  out  NUM_LANES*TAP_WIDTH  current tap per lane; lane i at [i*TAP_WIDTH +: TAP_WIDTH]
DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse to IOD
DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction; 1 = increment
DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse to IOD
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane out-of-range from IOD

Behaviour:
- Reset (SYNC_RST=1 at an edge): state IDLE; CMD_READY=1; DONE=0; ERR=0; ERR_LANE=0; BUSY=0; all MOVE, DIRECTION and LOAD outputs 0; every TAP_CUR lane = INIT_TAP. Reset mid-command aborts immediately, with no further pulses.
- Handshake: accept on CMD_VALID & CMD_READY. CMD_READY = (state==IDLE). CMD_LANE, CMD_TAP and CMD_LOAD are registered at accept. Accepting a command clears ERR.
- CMD_LANE >= NUM_LANES: the command is accepted and no pulse is issued. ERR=1, ERR_LANE=CMD_LANE (truncated), DONE pulses at cycle 1.
- Target: tgt = min(CMD_TAP, MAX_TAP).
- States: IDLE, SETUP, STEP, SETTLE, LDP, LDSETTLE, FIN.
- Move command (accept = cycle 0):
  - tgt==TAP_CUR[lane]: go to FIN; DONE pulses at cycle 1; no pulses issued.
  - Otherwise SETUP (cycle 1): DIRECTION[lane] = (tgt > cur), held stable until FIN.
  - STEP: MOVE[lane]=1 for exactly one cycle; TAP_CUR[lane] is incremented or decremented by 1 on the same edge.
  - SETTLE: SETTLE_CYCLES cycles. In the last SETTLE cycle, sample OUT_OF_RANGE[lane]:
    - High: undo the last count change, set ERR=1 and ERR_LANE=lane, go to FIN.
    - Else if cur==tgt: go to FIN.
    - Else: go to STEP.
  - For N steps, DONE pulses at cycle 2 + N*(1+SETTLE_CYCLES).
- Load command: LDP (cycle 1) drives LOAD[lane]=1 for one cycle and sets TAP_CUR[lane]=INIT_TAP. LDSETTLE lasts SETTLE_CYCLES cycles. FIN: DONE pulses at cycle 2+SETTLE_CYCLES. OUT_OF_RANGE is ignored on load.
- FIN: DONE=1 for one cycle, DIRECTION cleared to 0, return to IDLE. CMD_READY rises on the cycle after DONE.
- BUSY = (state != IDLE).
- At most one lane is driven at a time. Non-addressed lanes' MOVE, LOAD and DIRECTION stay 0.
- Counters never wrap: TAP_CUR stays within 0..MAX_TAP.

Test Plan:
1. Reset, SETTLE_CYCLES=2, move lane 3 to tap 4 (INIT_TAP=1) -> DIRECTION[3]=1 from cycle 1; MOVE[3] pulses at cycles 2, 5, 8; DONE at cycle 11; TAP_CUR lane3=4.
2. Then move lane 3 to tap 2 -> DIRECTION[3]=0; 2 pulses; DONE at cycle 8; TAP_CUR lane3=2; other lanes remain 1.
3. Move lane 0 to 1 (equal to current) -> no MOVE; DONE at cycle 1; ERR=0.
4. Move lane 5 to 10, with OUT_OF_RANGE[5] forced high after the 3rd pulse -> ERR=1, ERR_LANE=5, TAP_CUR lane5=3, DONE after the 3rd settle.
5. Move lane 7 to 300 with MAX_TAP=255, TAP_WIDTH=9 -> saturates at 255; then load lane 7 -> LOAD[7] pulse at cycle 1, TAP_CUR lane7=1, DONE at cycle 4.
6. Assert SYNC_RST during a move's SETTLE state -> all outputs at reset values the next cycle; CMD_READY=1; no further MOVE pulses.
